// File: rtl/aqua_pkg.sv
// Shared types for the BRU -> predictor feedback path and the BTB array.
// Tags are stored at full width so any power-of-two BTB depth fits.
package aqua_pkg;

    typedef struct packed {
        logic        update_en;
        logic [31:0] pc_lookup;
        logic [31:0] target;
        logic        taken;
        logic        valid;
    } branch_t;

    localparam int BTB_ENTRIES = 16;
    localparam int BTB_TAG_W = 30;
    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter step: up on taken, down on not-taken.
module sat_counter2 (
    input  logic [1:0] ctr_in,
    input  logic       taken,
    output logic [1:0] ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (taken) begin
            if (ctr_in != 2'b11) ctr_out = ctr_in + 2'd1;
        end else begin
            if (ctr_in != 2'b00) ctr_out = ctr_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; trained by the BRU,
// looked up combinationally by fetch.
module branch_predictor
    import aqua_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  branch_t     i_bru_prd_pkg,
    input  logic [31:0] i_fetch_pc,
    output logic        o_prd_hit,
    output logic        o_prd_taken,
    output logic [31:0] o_prd_target
);

    localparam int IDX_W = $clog2(ENTRIES);

    function automatic logic [BTB_TAG_W-1:0] tag_of(input logic [29:0] word);
        return word >> IDX_W;
    endfunction

    btb_entry_t btb [ENTRIES];

    logic [IDX_W-1:0]     f_idx;
    btb_entry_t           f_ent;
    logic [IDX_W-1:0]     u_idx;
    logic [BTB_TAG_W-1:0] u_tag;
    btb_entry_t           u_ent;
    logic                 u_hit;
    logic                 upd;
    logic [1:0]           ctr_next;
    logic                 unused_pc_lsb;

    assign unused_pc_lsb = ^i_bru_prd_pkg.pc_lookup[1:0];

    // Lookup: no bypass, so same-cycle updates are seen next cycle.
    assign f_idx = i_fetch_pc[IDX_W+1:2];
    assign f_ent = btb[f_idx];
    assign o_prd_hit = f_ent.valid && (f_ent.tag == tag_of(i_fetch_pc[31:2]));
    assign o_prd_taken = o_prd_hit && f_ent.ctr[1];
    assign o_prd_target = o_prd_taken ? f_ent.target : i_fetch_pc + 32'd4;

    assign upd = i_bru_prd_pkg.valid && i_bru_prd_pkg.update_en;
    assign u_idx = i_bru_prd_pkg.pc_lookup[IDX_W+1:2];
    assign u_tag = tag_of(i_bru_prd_pkg.pc_lookup[31:2]);
    assign u_ent = btb[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

    sat_counter2 u_ctr (
        .ctr_in  (u_ent.ctr),
        .taken   (i_bru_prd_pkg.taken),
        .ctr_out (ctr_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < ENTRIES; k++) btb[k] <= '0;
        end else if (upd) begin
            if (u_hit) begin
                btb[u_idx].ctr <= ctr_next;
                if (i_bru_prd_pkg.taken)
                    btb[u_idx].target <= i_bru_prd_pkg.target;
            end else if (i_bru_prd_pkg.taken) begin
                // Only taken branches allocate; replaces any alias.
                btb[u_idx] <= '{valid: 1'b1,
                                tag: u_tag,
                                target: i_bru_prd_pkg.target,
                                ctr: CTR_WEAK_TAKEN};
            end
        end
    end

endmodule
